// File: rtl/hazard_pkg.sv
// Shared constants and width helper for the forwarding / hazard unit.
package hazard_pkg;
   localparam int FWD_SEL_RF  = 0;
   localparam int DEF_MAX_LAT = 4;
   localparam int LAT_ALU     = 1;
   localparam int LAT_LOAD    = 2;
   localparam int LAT_MULDIV  = DEF_MAX_LAT;

   function automatic int sel_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding priority matcher: the youngest writing stage that targets src wins.
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int FWD_STAGES = 2,
   parameter int SEL_W      = sel_w(FWD_STAGES)
) (
   input  logic [REG_AW-1:0]            src,
   input  logic [FWD_STAGES-1:0]        stg_we,
   input  logic [FWD_STAGES*REG_AW-1:0] stg_reg,
   output logic [SEL_W-1:0]             sel
);

   // Walk oldest to youngest so the youngest match is the last assignment.
   always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (stg_we[k] && (stg_reg[k*REG_AW +: REG_AW] != '0) &&
             (stg_reg[k*REG_AW +: REG_AW] == src)) begin
            sel = SEL_W'(k + 1);
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, per-register latency scoreboard with ID-stage stall,
// and a saturating stall-cycle counter.
module fwd_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int MAX_LAT    = LAT_MULDIV,
   parameter int CNT_W      = 32
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      issue_valid,
   input  logic                                      issue_regwrite,
   input  logic [REG_AW-1:0]                         issue_dst,
   input  logic [sel_w(MAX_LAT)-1:0]                 issue_lat,
   input  logic [NUM_SRC*REG_AW-1:0]                 src_id,
   input  logic [NUM_SRC*REG_AW-1:0]                 src_ex,
   input  logic [FWD_STAGES-1:0]                     stg_we,
   input  logic [FWD_STAGES*REG_AW-1:0]              stg_reg,
   input  logic                                      flush,
   output logic [NUM_SRC*sel_w(FWD_STAGES)-1:0]      fwd_sel,
   output logic                                      stall,
   output logic [CNT_W-1:0]                          stall_cnt
);

   localparam int LAT_W  = sel_w(MAX_LAT);
   localparam int SEL_W  = sel_w(FWD_STAGES);
   localparam int NUM_RG = 2 ** REG_AW;

   logic [LAT_W-1:0] busy [NUM_RG];
   logic [LAT_W-1:0] eff_lat;
   logic             hazard;
   logic             load_en;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
      fwd_select #(
         .REG_AW     (REG_AW),
         .FWD_STAGES (FWD_STAGES),
         .SEL_W      (SEL_W)
      ) u_fwd_select (
         .src     (src_ex[i*REG_AW +: REG_AW]),
         .stg_we  (stg_we),
         .stg_reg (stg_reg),
         .sel     (fwd_sel[i*SEL_W +: SEL_W])
      );
   end

   always_comb begin
      eff_lat = issue_lat;
      if (issue_lat < LAT_W'(LAT_ALU)) begin
         eff_lat = LAT_W'(LAT_ALU);
      end else if (issue_lat > LAT_W'(MAX_LAT)) begin
         eff_lat = LAT_W'(MAX_LAT);
      end
   end

   // busy==1 means the result is forwardable next cycle, so only >1 stalls.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((src_id[i*REG_AW +: REG_AW] != '0) &&
             (busy[src_id[i*REG_AW +: REG_AW]] > LAT_W'(1))) begin
            hazard = 1'b1;
         end
      end
   end

   assign stall   = issue_valid & ~flush & hazard;
   assign load_en = issue_valid & issue_regwrite & ~stall & ~flush & (issue_dst != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_RG; r++) begin
            busy[r] <= '0;
         end
      end else begin
         busy[0] <= '0;
         for (int r = 1; r < NUM_RG; r++) begin
            if (flush) begin
               busy[r] <= '0;
            end else if (load_en && (issue_dst == REG_AW'(r))) begin
               busy[r] <= eff_lat;
            end else if (busy[r] != '0) begin
               busy[r] <= busy[r] - LAT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined MIPS core. It generalises EX-stage operand forwarding to NUM_SRC source operands and FWD_STAGES result-producing stages. It adds a per-register latency scoreboard that detects multi-cycle producer hazards (load-use, mult/div) and raises an ID-stage stall. It also keeps a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline registers and drives the operand muxes and the pipeline stall/bubble logic.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero and is never forwarded or marked busy.
NUM_SRC, 2, source operands per instruction (RS, RT).
FWD_STAGES, 2, forwarding stages after EX; index 0 is youngest (MEM), index 1 is WB.
MAX_LAT, 4, maximum producer latency in cycles.
CNT_W, 32, stall performance counter width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
issue_valid  in  1  the instruction in ID advances to EX this cycle, unless stall is asserted.
issue_regwrite  in  1  the issuing instruction writes a register.
issue_dst  in  REG_AW  destination register of the issuing instruction.
issue_lat  in  clog2(MAX_LAT+1)  cycles until the result is forwardable: 1 = ALU, 2 = load, up to MAX_LAT.
src_id  in  NUM_SRC*REG_AW  ID-stage source registers, packed with operand 0 in the LSBs.
src_ex  in  NUM_SRC*REG_AW  EX-stage source registers, packed the same way.
stg_we  in  FWD_STAGES  RegWrite of each forwarding stage.
stg_reg  in  FWD_STAGES*REG_AW  destination register of each forwarding stage.
flush  in  1  pipeline-wide flush (exception or redirect).
fwd_sel  out  NUM_SRC*clog2(FWD_STAGES+1)  per-operand mux select.
stall  out  1  hold PC and IF/ID, insert an EX bubble.
stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Forwarding is combinational, zero latency, evaluated separately for each EX operand i.
  - A stage k matches when stg_we[k]=1, stg_reg[k]!=0 and stg_reg[k]==src_ex[i].
  - fwd_sel[i] = k+1 for the lowest-index (youngest) matching stage; otherwise 0, meaning the register file.
  - With FWD_STAGES=2: MEM is 1, WB is 2, and MEM wins when both match.
- Scoreboard: one down-counter busy[r] per register r, clog2(MAX_LAT+1) bits wide.
- Each cycle, every nonzero busy[r] decrements by 1.
- Load: when issue_valid & issue_regwrite & !stall & issue_dst!=0, busy[issue_dst] <= eff_lat.
  - eff_lat is issue_lat clamped to the range 1..MAX_LAT; issue_lat=0 is treated as 1.
  - A load overrides the decrement for that register in the same cycle.
- stall = issue_valid & !flush & (some operand i has src_id[i]!=0 and busy[src_id[i]] > 1).
- Stall timing:
  - busy==1: the producer is forwardable next cycle, so no stall.
  - ALU producer (lat 1): back-to-back issue, 0 stall cycles.
  - Load producer (lat 2): 1 stall cycle.
  - Producer with lat L: L-1 stall cycles.
- Self-dependence (src == dst of the same instruction) is checked against the pre-load counter value.
- While stall=1, no scoreboard load occurs; counters keep decrementing.
- flush: all busy[r] <= 0 on the next edge, no load that cycle, stall forced to 0.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones (no wrap).
- Reset: all busy[r] = 0 and stall_cnt = 0 on the next edge.
  - Outputs after reset: stall=0; fwd_sel follows its inputs and is 0 when stg_we=0.
  - A reset during a stall clears the stall on the next cycle.
- Simultaneous rst and flush: rst dominates.

Decomposition:
- Shared package hazard_pkg holds:
  - FWD_SEL_RF = 0 constant;
  - latency constants LAT_ALU=1, LAT_LOAD=2, LAT_MULDIV=MAX_LAT;
  - function sel_w(n) = clog2(n+1).
- One sub-module, fwd_select, is instantiated NUM_SRC times. It is the per-operand combinational priority matcher (src_ex[i] and stg_* in, fwd_sel[i] out).
- The scoreboard and stall counter stay in the top module.

Test Plan:
1. Reset, then stg_we=2'b11, stg_reg={5'd3,5'd3}, src_ex={5'd3,5'd3} -> fwd_sel=2'b01 for both operands (MEM priority); set stg_reg[0]=5'd0 -> fwd_sel=2'b10.
2. Register zero: stg_we=2'b01, stg_reg[0]=0, src_ex operand 0 = 0 -> fwd_sel=0. Issue with dst=0, lat=4 -> busy stays 0, no later stall on r0.
3. Load-use: issue dst=r8, lat=2; next cycle src_id={r8,r9} -> stall=1 for exactly 1 cycle, stall_cnt=1. ALU lat=1 producer -> stall never asserted.
4. Mul lat=4 to r10, then consumer of r10 -> stall high for 3 consecutive cycles, then low. Same test with issue_lat=7 (clamped to 4) -> still 3 stall cycles.
5. Flush: mid-stall on a lat=4 producer, pulse flush -> stall=0 in the flush cycle and afterwards; consumer issues and the scoreboard is empty.
6. Saturation (CNT_W=4 override): hold a stall condition for 20 cycles -> stall_cnt stops at 15. Assert rst -> stall_cnt=0 and stall=0 on the next cycle.
